// File: rtl/cp0_regs_pkg.sv
// CP0 register numbers, field layouts and write masks shared by
// the CP0 register file and the exception unit.
package cp0_regs_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam int          STATUS_BEV   = 22;

  typedef struct packed {
    logic [8:0] rsv31;
    logic       bev;
    logic [5:0] rsv21;
    logic [7:0] im;
    logic [5:0] rsv7;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsv29;
    logic [7:0]  ip;
    logic        rsv7;
    logic [4:0]  exc;
    logic [1:0]  rsv1;
  } cp0_cause_t;

  typedef struct packed {
    logic        we;
    logic        bd;
    logic        exl;
    logic [31:0] epc;
    logic [31:0] bva;
    logic [4:0]  exc;
  } reg_error;

endpackage

// File: rtl/cp0_regs_timer.sv
// Count/Compare timer: prescaled Count, Compare and a sticky
// match flag that only a Compare write clears.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic          upd;
  logic [31:0]   count_n;

  always_comb begin
    tick    = (div == DIV_LAST);
    count_n = count;
    upd     = 1'b0;
    if (count_we) begin
      count_n = count_wdata;
      upd     = 1'b1;
    end else if (tick) begin
      count_n = count + 32'd1;
      upd     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (count_we || tick) div <= '0;
      else                  div <= div + DW'(1);
      count <= count_n;
      if (compare_we) compare <= compare_wdata;
      // a Compare write acknowledges the timer even on a same-cycle match
      if (compare_we)
        timer_pend <= 1'b0;
      else if (upd && count_n == compare)
        timer_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: exception/ERET/MTC0 state updates, MFC0 reads,
// Count/Compare timer and masked interrupt vector.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_error    cp0w,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  input  logic [5:0]  hw_intr,
  output logic [7:0]  intr_vect,
  output logic [31:0] epc
);

  cp0_status_t status, status_n;
  logic [31:0] bva, bva_n, epc_n;
  logic        bd, bd_n;
  logic [4:0]  exc, exc_n;
  logic [1:0]  ip_sw, ip_sw_n;
  logic [5:0]  ip_hw;
  logic [7:0]  ip;
  cp0_cause_t  cause;
  logic [31:0] count, compare;
  logic        timer_pend;
  logic        wr_status, wr_cause, wr_epc;

  assign wr_status = mtc0_we && mtc0_addr == CP0_STATUS;
  assign wr_cause  = mtc0_we && mtc0_addr == CP0_CAUSE;
  assign wr_epc    = mtc0_we && mtc0_addr == CP0_EPC;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_we      (mtc0_we && mtc0_addr == CP0_COUNT),
    .count_wdata   (mtc0_data),
    .compare_we    (mtc0_we && mtc0_addr == CP0_COMPARE),
    .compare_wdata (mtc0_data),
    .count         (count),
    .compare       (compare),
    .timer_pend    (timer_pend)
  );

  // later assignments win: exception over ERET over MTC0
  always_comb begin
    status_n = status;
    epc_n    = epc;
    bd_n     = bd;
    exc_n    = exc;
    bva_n    = bva;
    ip_sw_n  = ip_sw;
    if (wr_status)
      status_n = (status & ~STATUS_WMASK) | (mtc0_data & STATUS_WMASK);
    if (wr_cause)
      ip_sw_n = mtc0_data[9:8];
    if (wr_epc)
      epc_n = mtc0_data;
    if (eret)
      status_n.exl = 1'b0;
    if (cp0w.we) begin
      status_n.exl = 1'b1;
      exc_n        = cp0w.exc;
      epc_n        = status.exl ? epc : cp0w.epc;
      bd_n         = status.exl ? bd : cp0w.bd;
      if (cp0w.exc == EXC_ADEL || cp0w.exc == EXC_ADES)
        bva_n = cp0w.bva;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= RESET_STATUS;
      epc    <= '0;
      bd     <= 1'b0;
      exc    <= '0;
      bva    <= '0;
      ip_sw  <= '0;
      ip_hw  <= '0;
    end else begin
      status <= status_n;
      epc    <= epc_n;
      bd     <= bd_n;
      exc    <= exc_n;
      bva    <= bva_n;
      ip_sw  <= ip_sw_n;
      ip_hw  <= {hw_intr[5] | timer_pend, hw_intr[4:0]};
    end
  end

  assign ip = {ip_hw, ip_sw};

  always_comb begin
    cause       = '0;
    cause.bd    = bd;
    cause.ti    = timer_pend;
    cause.ip    = ip;
    cause.exc   = exc;
  end

  assign intr_vect = (status.ie && !status.exl) ? (ip & status.im) : 8'h00;

  always_comb begin
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_data = bva;
      CP0_COUNT:    mfc0_data = count;
      CP0_COMPARE:  mfc0_data = compare;
      CP0_STATUS:   mfc0_data = status;
      CP0_CAUSE:    mfc0_data = cause;
      CP0_EPC:      mfc0_data = epc;
      default:      mfc0_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: reset, masks, interrupts,
// exceptions, timer and same-cycle priority.
`timescale 1ns/1ps
module tb_cp0_regs;
  import cp0_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  reg_error    cp0w = '0;
  logic        eret = 1'b0;
  logic        mtc0_we = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic [4:0]  mfc0_addr = '0;
  logic [31:0] mfc0_data;
  logic [5:0]  hw_intr = '0;
  logic [7:0]  intr_vect;
  logic [31:0] epc;

  int errors = 0;
  int checks = 0;

  cp0_regs #(.COUNT_DIV(2), .RESET_STATUS(32'h0040_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .cp0w      (cp0w),
    .eret      (eret),
    .mtc0_we   (mtc0_we),
    .mtc0_addr (mtc0_addr),
    .mtc0_data (mtc0_data),
    .mfc0_addr (mfc0_addr),
    .mfc0_data (mfc0_data),
    .hw_intr   (hw_intr),
    .intr_vect (intr_vect),
    .epc       (epc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_data = d;
    step();
    mtc0_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0_addr = a;
    #0.5;
    d = mfc0_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(CP0_STATUS, d); checks++;
    if (d !== 32'h0040_0000) begin errors++;
      $display("FAIL reset_status got=%h exp=%h", d, 32'h0040_0000); end
    rd(CP0_CAUSE, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL reset_cause got=%h exp=0", d); end
    rd(CP0_EPC, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL reset_epc got=%h exp=0", d); end
    rd(CP0_COUNT, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL reset_count got=%h exp=0", d); end
    checks++;
    if (intr_vect !== 8'h0) begin errors++;
      $display("FAIL reset_intr got=%h exp=0", intr_vect); end
  endtask

  task automatic test_reset_discard();
    logic [31:0] d;
    mtc0(CP0_EPC, 32'h0000_5555);
    rst = 1'b1;
    mtc0(CP0_EPC, 32'h0000_7777);
    rst = 1'b0;
    checks++;
    if (epc !== 32'h0) begin errors++;
      $display("FAIL reset_discard got=%h exp=0", epc); end
    mtc0(5'd3, 32'hFFFF_FFFF);
    rd(5'd3, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL unmapped_read got=%h exp=0", d); end
  endtask

  task automatic test_masks();
    logic [31:0] d;
    mtc0(CP0_STATUS, 32'hFFFF_FFFF);
    rd(CP0_STATUS, d); checks++;
    if (d !== 32'h0040_FF03) begin errors++;
      $display("FAIL status_mask got=%h exp=%h", d, 32'h0040_FF03); end
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    rd(CP0_CAUSE, d); checks++;
    if (d !== 32'h0000_0300) begin errors++;
      $display("FAIL cause_mask got=%h exp=%h", d, 32'h0000_0300); end
    checks++;
    if (intr_vect !== 8'h0) begin errors++;
      $display("FAIL exl_masks_sw got=%h exp=0", intr_vect); end
    mtc0(CP0_STATUS, 32'h0);
    mtc0(CP0_CAUSE, 32'h0);
  endtask

  task automatic test_intr();
    mtc0(CP0_STATUS, 32'h0000_FF01);
    checks++;
    if (intr_vect !== 8'h0) begin errors++;
      $display("FAIL intr_idle got=%h exp=0", intr_vect); end
    hw_intr = 6'b000001;
    step();
    checks++;
    if (intr_vect !== 8'h04) begin errors++;
      $display("FAIL intr_hw0 got=%h exp=04", intr_vect); end
    hw_intr = 6'b100000;
    step();
    checks++;
    if (intr_vect !== 8'h80) begin errors++;
      $display("FAIL intr_hw5 got=%h exp=80", intr_vect); end
    mtc0(CP0_STATUS, 32'h0000_FF03);
    checks++;
    if (intr_vect !== 8'h0) begin errors++;
      $display("FAIL intr_exl got=%h exp=0", intr_vect); end
    hw_intr = '0;
    mtc0(CP0_STATUS, 32'h0);
  endtask

  task automatic test_exception();
    logic [31:0] d;
    cp0w = '{we: 1'b1, bd: 1'b1, exl: 1'b0, epc: 32'hBFC0_0100,
             bva: 32'h0000_1233, exc: EXC_ADEL};
    step();
    cp0w = '0;
    checks++;
    if (epc !== 32'hBFC0_0100) begin errors++;
      $display("FAIL exc_epc got=%h exp=bfc00100", epc); end
    rd(CP0_CAUSE, d); checks++;
    if (d !== 32'h8000_0010) begin errors++;
      $display("FAIL exc_cause got=%h exp=80000010", d); end
    rd(CP0_BADVADDR, d); checks++;
    if (d !== 32'h0000_1233) begin errors++;
      $display("FAIL exc_bva got=%h exp=00001233", d); end
    rd(CP0_STATUS, d); checks++;
    if (d !== 32'h0040_0002) begin errors++;
      $display("FAIL exc_exl got=%h exp=00400002", d); end
    cp0w = '{we: 1'b1, bd: 1'b0, exl: 1'b1, epc: 32'h0000_5555,
             bva: 32'h0000_8888, exc: EXC_ADES};
    step();
    cp0w = '0;
    checks++;
    if (epc !== 32'hBFC0_0100) begin errors++;
      $display("FAIL nested_epc got=%h exp=bfc00100", epc); end
    rd(CP0_CAUSE, d); checks++;
    if (d !== 32'h8000_0014) begin errors++;
      $display("FAIL nested_cause got=%h exp=80000014", d); end
    rd(CP0_BADVADDR, d); checks++;
    if (d !== 32'h0000_8888) begin errors++;
      $display("FAIL nested_bva got=%h exp=00008888", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(CP0_STATUS, d); checks++;
    if (d !== 32'h0040_0000) begin errors++;
      $display("FAIL eret_exl got=%h exp=00400000", d); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT, 32'd0);
    repeat (19) step();
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b0) begin errors++;
      $display("FAIL timer_early ti=%b exp=0", d[30]); end
    step();
    rd(CP0_COUNT, d); checks++;
    if (d !== 32'd10) begin errors++;
      $display("FAIL timer_count got=%0d exp=10", d); end
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b1 || d[15] !== 1'b0) begin errors++;
      $display("FAIL timer_ti ti=%b ip7=%b exp=1,0", d[30], d[15]); end
    step();
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b1 || d[15] !== 1'b1) begin errors++;
      $display("FAIL timer_ip7 ti=%b ip7=%b exp=1,1", d[30], d[15]); end
    mtc0(CP0_COMPARE, 32'h100);
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b0) begin errors++;
      $display("FAIL timer_clear ti=%b exp=0", d[30]); end
    step();
    rd(CP0_CAUSE, d); checks++;
    if (d[15] !== 1'b0) begin errors++;
      $display("FAIL timer_ip7_clear ip7=%b exp=0", d[15]); end
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd4);
    step();
    mtc0(CP0_COMPARE, 32'd5);
    rd(CP0_COUNT, d); checks++;
    if (d !== 32'd5) begin errors++;
      $display("FAIL race_count got=%0d exp=5", d); end
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b0) begin errors++;
      $display("FAIL race_clear_wins ti=%b exp=0", d[30]); end
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    step();
    step();
    rd(CP0_COUNT, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL count_wrap got=%h exp=0", d); end
    rd(CP0_CAUSE, d); checks++;
    if (d[30] !== 1'b0) begin errors++;
      $display("FAIL wrap_silent ti=%b exp=0", d[30]); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cp0w = '{we: 1'b1, bd: 1'b0, exl: 1'b0, epc: 32'hAAAA_0000,
             bva: 32'h0000_0077, exc: EXC_INT};
    mtc0_we = 1'b1; mtc0_addr = CP0_EPC; mtc0_data = 32'h0000_1234;
    step();
    mtc0_we = 1'b0;
    cp0w = '0;
    checks++;
    if (epc !== 32'hAAAA_0000) begin errors++;
      $display("FAIL prio_epc got=%h exp=aaaa0000", epc); end
    rd(CP0_BADVADDR, d); checks++;
    if (d !== 32'h0) begin errors++;
      $display("FAIL prio_bva_int got=%h exp=0", d); end
    cp0w = '{we: 1'b1, bd: 1'b0, exl: 1'b1, epc: 32'h0,
             bva: 32'h0, exc: EXC_INT};
    eret = 1'b1;
    step();
    eret = 1'b0;
    cp0w = '0;
    rd(CP0_STATUS, d); checks++;
    if (d[1] !== 1'b1) begin errors++;
      $display("FAIL prio_eret_exl exl=%b exp=1", d[1]); end
    eret = 1'b1;
    mtc0_we = 1'b1; mtc0_addr = CP0_STATUS; mtc0_data = 32'h0000_0003;
    step();
    mtc0_we = 1'b0;
    eret = 1'b0;
    rd(CP0_STATUS, d); checks++;
    if (d !== 32'h0040_0001) begin errors++;
      $display("FAIL prio_eret_mtc0 got=%h exp=00400001", d); end
  endtask

  initial begin
    test_reset();
    test_reset_discard();
    test_masks();
    test_intr();
    test_exception();
    test_timer();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
